// File: rtl/ycr1_tcm_pkg.sv
`default_nettype none
// ============================================================================
// | Module      : ycr1_tcm_pkg                                               |
// | Description : Items shared by the imem and dmem TCM bridges: bridge      |
// |               state encoding and the address window/alignment checks.    |
// | Revision    : 1.0                                                        |
// ============================================================================
package ycr1_tcm_pkg;

    `include "ycr1_memif.svh"

    // IDLE: no response due this cycle; DATA: a response beat is presented.
    typedef enum logic {
        TCM_ST_IDLE = 1'b0,
        TCM_ST_DATA = 1'b1
    } tcm_state_e;

    // An address belongs to the TCM when none of its masked bits are set.
    function automatic logic tcm_in_window(input logic [31:0] addr,
                                           input logic [31:0] mask);
        return ((addr & mask) == 32'h0);
    endfunction

    // A new request may touch the SRAM only if it is a word-aligned read
    // inside the window.
    function automatic logic tcm_req_ok(input logic        cmd,
                                        input logic [31:0] addr,
                                        input logic [31:0] mask);
        return (cmd == YCR1_MEM_CMD_RD) && (addr[1:0] == 2'b00)
               && tcm_in_window(addr, mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ycr1_memif.svh
`default_nettype none
// ============================================================================
// | File        : ycr1_memif.svh                                             |
// | Description : Shared core memory-interface widths, command and response  |
// |               encodings used by every imem/dmem target.                  |
// | Revision    : 1.0                                                        |
// ============================================================================
`ifndef YCR1_MEMIF_SVH
`define YCR1_MEMIF_SVH

localparam int YCR1_IMEM_AWIDTH = 32;
localparam int YCR1_IMEM_DWIDTH = 32;
localparam int YCR1_IMEM_BSIZE  = 4;

typedef enum logic {
    YCR1_MEM_CMD_RD = 1'b0,
    YCR1_MEM_CMD_WR = 1'b1
} type_ycr1_mem_cmd_e;

typedef enum logic [1:0] {
    YCR1_MEM_RESP_NOTRDY = 2'b00,
    YCR1_MEM_RESP_RDY_OK = 2'b01,
    YCR1_MEM_RESP_RDY_ER = 2'b10
} type_ycr1_mem_resp_e;

`endif
`default_nettype wire

// File: rtl/ycr1_imem_tcm_bridge.sv
`default_nettype none
// ============================================================================
// | Module      : ycr1_imem_tcm_bridge                                       |
// | Description : imem router target reading a single-port synchronous TCM   |
// |               SRAM (1-cycle latency); single reads, incrementing bursts, |
// |               error beat for writes, misalignment and out-of-window.     |
// | Revision    : 1.0                                                        |
// ============================================================================
module ycr1_imem_tcm_bridge
    import ycr1_tcm_pkg::*;
#(
    parameter int          SRAM_AW  = 9,
    parameter logic [31:0] WIN_MASK = 32'h0000_F800
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        imem_req_ack,
    input  logic                        imem_req,
    input  logic                        imem_cmd,
    input  logic [YCR1_IMEM_AWIDTH-1:0] imem_addr,
    input  logic [YCR1_IMEM_BSIZE-1:0]  imem_bl,
    output logic [YCR1_IMEM_DWIDTH-1:0] imem_rdata,
    output logic [1:0]                  imem_resp,
    output logic                        sram_csb,
    output logic [SRAM_AW-1:0]          sram_addr,
    input  logic [31:0]                 sram_dout
);

    localparam logic [YCR1_IMEM_BSIZE-1:0] c_rem_one = {{(YCR1_IMEM_BSIZE-1){1'b0}}, 1'b1};

    tcm_state_e                   state_q, state_d;
    logic [31:0]                  addr_q,  addr_d;
    logic [YCR1_IMEM_BSIZE-1:0]   rem_q,   rem_d;
    logic                         err_q,   err_d;
    // Set when addr_q was produced by a carry out of bit 31; such an
    // address is treated as outside the window whatever the mask says.
    logic                         wrap_q,  wrap_d;

    logic        w_beat_ok;
    logic        w_last_ok;
    logic        w_accept;
    logic        w_req_ok;
    logic        w_cont;
    logic        w_cont_ok;
    logic        w_sram_rd;
    logic [32:0] w_req_next;
    logic [32:0] w_cont_next;

    assign w_beat_ok    = (state_q == TCM_ST_DATA) && !err_q;
    assign w_last_ok    = w_beat_ok && (rem_q == '0);
    assign imem_req_ack = (state_q == TCM_ST_IDLE) || w_last_ok;
    assign w_accept     = imem_req && imem_req_ack;
    assign w_req_ok     = tcm_req_ok(imem_cmd, imem_addr, WIN_MASK);
    assign w_cont       = w_beat_ok && (rem_q != '0);
    assign w_cont_ok    = w_cont && !wrap_q && tcm_in_window(addr_q, WIN_MASK);
    assign w_req_next   = {1'b0, imem_addr} + 33'd4;
    assign w_cont_next  = {1'b0, addr_q} + 33'd4;

    // SRAM command: a continuing burst beat or a fresh good request; the
    // address is forced to zero whenever no read is issued.
    assign w_sram_rd = (w_accept && w_req_ok) || w_cont_ok;
    assign sram_csb  = !w_sram_rd;
    assign sram_addr = !w_sram_rd ? '0
                     : w_cont     ? addr_q[SRAM_AW+1:2]
                     :              imem_addr[SRAM_AW+1:2];

    // Response side depends only on registers and SRAM data.
    assign imem_resp  = (state_q == TCM_ST_IDLE) ? YCR1_MEM_RESP_NOTRDY
                      : err_q                    ? YCR1_MEM_RESP_RDY_ER
                      :                            YCR1_MEM_RESP_RDY_OK;
    assign imem_rdata = w_beat_ok ? sram_dout : '0;

    // Next-state: accept a request, continue/abort a burst, or fall idle.
    always_comb begin
        state_d = TCM_ST_IDLE;
        addr_d  = addr_q;
        rem_d   = '0;
        err_d   = 1'b0;
        wrap_d  = wrap_q;
        if (w_accept) begin
            state_d = TCM_ST_DATA;
            if (w_req_ok) begin
                rem_d  = (imem_bl == '0) ? '0 : (imem_bl - c_rem_one);
                addr_d = w_req_next[31:0];
                wrap_d = w_req_next[32];
            end else begin
                err_d = 1'b1;
            end
        end else if (w_cont) begin
            state_d = TCM_ST_DATA;
            if (w_cont_ok) begin
                rem_d  = rem_q - c_rem_one;
                addr_d = w_cont_next[31:0];
                wrap_d = w_cont_next[32];
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TCM_ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ycr1_imem_tcm_bridge.sv
`default_nettype none
// ============================================================================
// | Module      : tb_ycr1_imem_tcm_bridge                                    |
// | Description : Directed self-checking bench for ycr1_imem_tcm_bridge      |
// |               with a behavioural one-cycle-latency SRAM.                 |
// | Revision    : 1.0                                                        |
// ============================================================================
module tb_ycr1_imem_tcm_bridge;
    import ycr1_tcm_pkg::*;

    localparam logic [31:0] c_ok = 32'd1;
    localparam logic [31:0] c_er = 32'd2;
    localparam logic [31:0] c_nr = 32'd0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_ack;
    logic        imem_req;
    logic        imem_cmd;
    logic [31:0] imem_addr;
    logic [3:0]  imem_bl;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_resp;
    logic        sram_csb;
    logic [8:0]  sram_addr;
    logic [31:0] sram_dout;

    logic [31:0] mem [0:511];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_reads = 0;

    ycr1_imem_tcm_bridge u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_ack (imem_req_ack),
        .imem_req     (imem_req),
        .imem_cmd     (imem_cmd),
        .imem_addr    (imem_addr),
        .imem_bl      (imem_bl),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .sram_csb     (sram_csb),
        .sram_addr    (sram_addr),
        .sram_dout    (sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: data appears the cycle after chip select is low.
    always @(posedge clk) begin
        if (!sram_csb) begin
            sram_dout <= mem[sram_addr];
            n_reads   <= n_reads + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic cmd, input logic [31:0] a, input logic [3:0] bl);
        imem_req  = req;
        imem_cmd  = cmd;
        imem_addr = a;
        imem_bl   = bl;
        #1;
    endtask

    logic [31:0] err_addr [0:2];
    logic        err_cmd  [0:2];

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hA500_0000 | i;
        mem[4] = 32'hDEAD_BEEF;
        err_addr[0] = 32'h0001_0000; err_cmd[0] = 1'b1;
        err_addr[1] = 32'h0001_0002; err_cmd[1] = 1'b0;
        err_addr[2] = 32'h0001_0800; err_cmd[2] = 1'b0;
        sram_dout = '0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0001_0040, 4'd0);
        cyc(); cyc();
        chk("rst_ack",   {31'b0, imem_req_ack}, 32'd1);
        chk("rst_resp",  {30'b0, imem_resp}, c_nr);
        chk("rst_rdata", imem_rdata, 32'h0);
        chk("rst_csb",   {31'b0, sram_csb}, 32'd1);
        chk("rst_saddr", {23'b0, sram_addr}, 32'd0);
        rst_n = 1'b1;

        // Single read of word 4
        cyc();
        drive(1'b1, 1'b0, 32'h0001_0010, 4'd1);
        chk("single_csb",   {31'b0, sram_csb}, 32'd0);
        chk("single_saddr", {23'b0, sram_addr}, 32'd4);
        cyc(); drive(1'b0, 1'b0, 32'h0, 4'd0);
        chk("single_resp",  {30'b0, imem_resp}, c_ok);
        chk("single_rdata", imem_rdata, 32'hDEAD_BEEF);
        chk("single_ack",   {31'b0, imem_req_ack}, 32'd1);
        cyc();
        chk("single_idle",  {30'b0, imem_resp}, c_nr);

        // Burst of 4 from word 0
        drive(1'b1, 1'b0, 32'h0001_0000, 4'd4);
        chk("burst_saddr0", {23'b0, sram_addr}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            cyc(); drive(1'b0, 1'b0, 32'h0, 4'd0);
            chk("burst_resp",  {30'b0, imem_resp}, c_ok);
            chk("burst_rdata", imem_rdata, 32'hA500_0000 | (k - 1));
            chk("burst_ack",   {31'b0, imem_req_ack}, (k == 4) ? 32'd1 : 32'd0);
            if (k < 4) chk("burst_saddr", {23'b0, sram_addr}, k);
        end
        cyc();
        chk("burst_idle", {30'b0, imem_resp}, c_nr);

        // Back-to-back singles of words 0,1,2
        drive(1'b1, 1'b0, 32'h0001_0000, 4'd1);
        chk("b2b_ack0", {31'b0, imem_req_ack}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            if (k < 3) drive(1'b1, 1'b0, 32'h0001_0000 + 4 * k, 4'd0);
            else       drive(1'b0, 1'b0, 32'h0, 4'd0);
            chk("b2b_resp",  {30'b0, imem_resp}, c_ok);
            chk("b2b_rdata", imem_rdata, 32'hA500_0000 | (k - 1));
            if (k < 3) begin
                chk("b2b_ack",   {31'b0, imem_req_ack}, 32'd1);
                chk("b2b_saddr", {23'b0, sram_addr}, k);
            end
        end
        cyc();
        chk("b2b_idle", {30'b0, imem_resp}, c_nr);

        // Write, misaligned and out-of-window requests
        for (int e = 0; e < 3; e++) begin
            n_reads = 0;
            drive(1'b1, err_cmd[e], err_addr[e], 4'd1);
            chk("err_csb0", {31'b0, sram_csb}, 32'd1);
            cyc(); drive(1'b0, 1'b0, 32'h0, 4'd0);
            chk("err_resp",  {30'b0, imem_resp}, c_er);
            chk("err_rdata", imem_rdata, 32'h0);
            chk("err_csb1",  {31'b0, sram_csb}, 32'd1);
            cyc();
            chk("err_idle",  {30'b0, imem_resp}, c_nr);
            chk("err_reads", n_reads, 32'd0);
        end

        // Burst crossing the window edge
        n_reads = 0;
        drive(1'b1, 1'b0, 32'h0001_07F8, 4'd4);
        cyc(); drive(1'b0, 1'b0, 32'h0, 4'd0);
        chk("win_resp1",  {30'b0, imem_resp}, c_ok);
        chk("win_rdata1", imem_rdata, 32'hA500_01FE);
        cyc();
        chk("win_resp2",  {30'b0, imem_resp}, c_ok);
        chk("win_rdata2", imem_rdata, 32'hA500_01FF);
        chk("win_csb2",   {31'b0, sram_csb}, 32'd1);
        cyc();
        chk("win_resp3",  {30'b0, imem_resp}, c_er);
        cyc();
        chk("win_resp4",  {30'b0, imem_resp}, c_nr);
        chk("win_reads",  n_reads, 32'd2);

        // Burst whose next address wraps past 2^32
        drive(1'b1, 1'b0, 32'hFFFF_07FC, 4'd2);
        chk("wrap_saddr", {23'b0, sram_addr}, 32'h1FF);
        cyc(); drive(1'b0, 1'b0, 32'h0, 4'd0);
        chk("wrap_resp1", {30'b0, imem_resp}, c_ok);
        chk("wrap_csb",   {31'b0, sram_csb}, 32'd1);
        cyc();
        chk("wrap_resp2", {30'b0, imem_resp}, c_er);
        cyc();
        chk("wrap_idle",  {30'b0, imem_resp}, c_nr);

        // Reset during the second beat of an 8-beat burst
        drive(1'b1, 1'b0, 32'h0001_0000, 4'd8);
        cyc(); drive(1'b0, 1'b0, 32'h0, 4'd0);
        chk("rmb_beat1", {30'b0, imem_resp}, c_ok);
        cyc();
        chk("rmb_beat2", {30'b0, imem_resp}, c_ok);
        rst_n = 1'b0;
        #1;
        chk("rmb_resp", {30'b0, imem_resp}, c_nr);
        chk("rmb_csb",  {31'b0, sram_csb}, 32'd1);
        chk("rmb_ack",  {31'b0, imem_req_ack}, 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rmb_nostale", {30'b0, imem_resp}, c_nr);
        drive(1'b1, 1'b0, 32'h0001_0010, 4'd0);
        chk("rmb_ack2", {31'b0, imem_req_ack}, 32'd1);
        cyc(); drive(1'b0, 1'b0, 32'h0, 4'd0);
        chk("rmb_resp2",  {30'b0, imem_resp}, c_ok);
        chk("rmb_rdata2", imem_rdata, 32'hDEAD_BEEF);
        cyc();
        chk("rmb_idle", {30'b0, imem_resp}, c_nr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
